aes_round_sequencer: RTL and testbench

- Control and state-holding stage directly upstream of the single-round AES-128 datapath.
- Accepts a plaintext block and cipher key over a valid/ready handshake, then performs the initial AddRoundKey.
- Iterates the round datapath for rounds 0..9, feeding back its result block and expanded round key each round.
- Presents the final ciphertext on a valid/ready output handshake. One block in flight at a time.

---
 rtl/aes_round_sequencer.sv | 101 ++++++++++
 tb/tb_aes_round_sequencer.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_sequencer.sv
// Control/state stage for a single-round AES-128 datapath: accepts a block and key,
// iterates the external round NUM_ROUNDS times, then holds the ciphertext for hand-off.
module aes_round_sequencer #(
   parameter int unsigned NUM_ROUNDS    = 10,
   parameter int unsigned ROUND_LATENCY = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_block,
   input  logic [127:0] in_key,
   output logic [3:0]   rnd_idx,
   output logic [127:0] rnd_block,
   output logic [127:0] rnd_key,
   input  logic [127:0] rnd_result,
   input  logic [127:0] rnd_next_key,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_cipher,
   output logic         busy
);

   localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS - 1);
   localparam logic [2:0] LAT_RELOAD = 3'(ROUND_LATENCY - 1);

   typedef enum logic [1:0] {
      IDLE,
      ROUND,
      DONE
   } state_t;

   state_t       st;
   logic [127:0] state_reg;
   logic [127:0] key_reg;
   logic [3:0]   round;
   logic [2:0]   lat_cnt;

   // Handshake flags are registered alongside the state so no output is combinational.
   always_ff @(posedge clk) begin
      if (!rst) begin
         st        <= IDLE;
         state_reg <= '0;
         key_reg   <= '0;
         round     <= '0;
         lat_cnt   <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (st)
            IDLE: begin
               if (in_valid) begin
                  state_reg <= in_block ^ in_key;
                  key_reg   <= in_key;
                  round     <= '0;
                  lat_cnt   <= LAT_RELOAD;
                  st        <= ROUND;
                  in_ready  <= 1'b0;
                  busy      <= 1'b1;
               end
            end
            ROUND: begin
               if (lat_cnt != '0) begin
                  lat_cnt <= lat_cnt - 3'd1;
               end else begin
                  state_reg <= rnd_result;
                  key_reg   <= rnd_next_key;
                  if (round == LAST_ROUND) begin
                     st        <= DONE;
                     out_valid <= 1'b1;
                  end else begin
                     round   <= round + 4'd1;
                     lat_cnt <= LAT_RELOAD;
                  end
               end
            end
            DONE: begin
               if (out_ready) begin
                  st        <= IDLE;
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: begin
               st        <= IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

   assign rnd_idx    = round;
   assign rnd_block  = state_reg;
   assign rnd_key    = key_reg;
   assign out_cipher = state_reg;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: one instance on a real AES round, one on a stub round
// with ROUND_LATENCY=3, both checked every cycle against a transaction-level model.
module tb_aes_round_sequencer;

   localparam logic [127:0] FIPS_P = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] FIPS_K = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] FIPS_C = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] APPC_P = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] APPC_K = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] APPC_C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic         iv_a, ir_a, ov_a, or_a, busy_a;
   logic [127:0] ib_a, ik_a, rblk_a, rkey_a, rres_a, rnk_a, oc_a;
   logic [3:0]   ridx_a;
   logic         iv_b, ir_b, ov_b, or_b, busy_b;
   logic [127:0] ib_b, ik_b, rblk_b, rkey_b, rres_b, rnk_b, oc_b;
   logic [3:0]   ridx_b;

   int n_cmp = 0;
   int n_bad = 0;

   // ---------------- AES reference functions ----------------
   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = '0;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xt(x);
      end
      return p;
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0]  r, s;
      logic [15:0] bb;
      r = 8'h01;
      s = x;
      for (int i = 1; i < 8; i++) begin
         s = gm(s, s);
         r = gm(r, s);
      end
      bb = {r, r};
      return r ^ bb[14:7] ^ bb[13:6] ^ bb[12:5] ^ bb[11:4] ^ 8'h63;
   endfunction

   function automatic logic [127:0] sub_shift(input logic [127:0] b);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[8*(15-(c*4+r)) +: 8] = sbox(b[8*(15-(((c+r)%4)*4+r)) +: 8]);
      return o;
   endfunction

   function automatic logic [127:0] mix(input logic [127:0] b);
      logic [127:0] o;
      logic [7:0] a0, a1, a2, a3;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = b[8*(15-(c*4+0)) +: 8];
         a1 = b[8*(15-(c*4+1)) +: 8];
         a2 = b[8*(15-(c*4+2)) +: 8];
         a3 = b[8*(15-(c*4+3)) +: 8];
         o[8*(15-(c*4+0)) +: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
         o[8*(15-(c*4+1)) +: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
         o[8*(15-(c*4+2)) +: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
         o[8*(15-(c*4+3)) +: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
      end
      return o;
   endfunction

   function automatic logic [127:0] kexp(input logic [127:0] k, input int unsigned i);
      logic [7:0]  rc;
      logic [31:0] rot, t, w0, w1, w2, w3;
      rc = 8'h01;
      for (int unsigned j = 0; j < i; j++) rc = xt(rc);
      rot = {k[23:0], k[31:24]};
      t = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])} ^ {rc, 24'h0};
      w0 = k[127:96] ^ t;
      w1 = k[95:64] ^ w0;
      w2 = k[63:32] ^ w1;
      w3 = k[31:0] ^ w2;
      return {w0, w1, w2, w3};
   endfunction

   function automatic logic [127:0] aes_round(input logic [127:0] b, input logic [127:0] k,
                                               input logic last);
      logic [127:0] t;
      t = sub_shift(b);
      if (!last) t = mix(t);
      return t ^ k;
   endfunction

   // Instance a: real AES round datapath (combinational, latency 1).
   assign rnk_a  = kexp(rkey_a, int'(ridx_a));
   assign rres_a = aes_round(rblk_a, rnk_a, ridx_a == 4'd9);
   // Instance b: stub datapath.
   assign rres_b = rblk_b + 128'd1;
   assign rnk_b  = rkey_b ^ {124'd0, ridx_b};

   aes_round_sequencer u_a (
      .clk(clk), .rst(rst), .in_valid(iv_a), .in_ready(ir_a), .in_block(ib_a), .in_key(ik_a),
      .rnd_idx(ridx_a), .rnd_block(rblk_a), .rnd_key(rkey_a), .rnd_result(rres_a),
      .rnd_next_key(rnk_a), .out_valid(ov_a), .out_ready(or_a), .out_cipher(oc_a), .busy(busy_a)
   );

   aes_round_sequencer #(.NUM_ROUNDS(10), .ROUND_LATENCY(3)) u_b (
      .clk(clk), .rst(rst), .in_valid(iv_b), .in_ready(ir_b), .in_block(ib_b), .in_key(ik_b),
      .rnd_idx(ridx_b), .rnd_block(rblk_b), .rnd_key(rkey_b), .rnd_result(rres_b),
      .rnd_next_key(rnk_b), .out_valid(ov_b), .out_ready(or_b), .out_cipher(oc_b), .busy(busy_b)
   );

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- transaction-level model ----------------
   // phase 0: waiting for a block, 1: rounds in progress, 2: ciphertext on offer
   int           m_phase [2];
   int           m_n     [2];
   logic         m_zero  [2];
   logic         m_on = 1'b0;
   int           m_lat   [2] = '{1, 3};
   logic [127:0] es [2][11];
   logic [127:0] ek [2][11];

   task automatic mdl_step(input int d, input logic rstv, input logic iv, input logic ordy,
                           input logic [127:0] p, input logic [127:0] k);
      if (!rstv) begin
         m_phase[d] = 0;
         m_zero[d]  = 1'b1;
         m_on       = 1'b1;
      end else begin
         case (m_phase[d])
            0: if (iv) begin
               m_phase[d] = 1;
               m_n[d]     = 0;
               m_zero[d]  = 1'b0;
               es[d][0]   = p ^ k;
               ek[d][0]   = k;
               for (int r = 1; r <= 10; r++) begin
                  if (d == 0) begin
                     ek[d][r] = kexp(ek[d][r-1], r - 1);
                     es[d][r] = aes_round(es[d][r-1], ek[d][r], r == 10);
                  end else begin
                     ek[d][r] = ek[d][r-1] ^ 128'(r - 1);
                     es[d][r] = es[d][0] + 128'(r);
                  end
               end
            end
            1: begin
               m_n[d]++;
               if (m_n[d] == 10 * m_lat[d]) m_phase[d] = 2;
            end
            default: if (ordy) m_phase[d] = 0;
         endcase
      end
   endtask

   task automatic mdl_cmp(input int d, input logic ir, input logic ov, input logic bsy,
                          input logic [3:0] idx, input logic [127:0] blk,
                          input logic [127:0] key, input logic [127:0] ciph);
      int r;
      logic [6:0]   ectl;
      logic [127:0] eb, ekk;
      if (m_phase[d] == 1) begin
         r    = m_n[d] / m_lat[d];
         ectl = {3'b001, 4'(r)};
      end else if (m_phase[d] == 2) begin
         r    = 10;
         ectl = {3'b011, 4'd9};
      end else begin
         r    = 10;
         ectl = {3'b100, m_zero[d] ? 4'd0 : 4'd9};
      end
      eb  = (m_phase[d] == 0 && m_zero[d]) ? '0 : es[d][r];
      ekk = (m_phase[d] == 0 && m_zero[d]) ? '0 : ek[d][r];
      chk($sformatf("model%0d_ctrl{ir,ov,busy,idx}", d), 128'({ir, ov, bsy, idx}), 128'(ectl));
      chk($sformatf("model%0d_rnd_block", d), blk, eb);
      chk($sformatf("model%0d_rnd_key", d), key, ekk);
      chk($sformatf("model%0d_out_cipher", d), ciph, eb);
   endtask

   always @(posedge clk) begin
      mdl_step(0, rst, iv_a, or_a, ib_a, ik_a);
      mdl_step(1, rst, iv_b, or_b, ib_b, ik_b);
   end

   always @(negedge clk) begin
      if (m_on) begin
         mdl_cmp(0, ir_a, ov_a, busy_a, ridx_a, rblk_a, rkey_a, oc_a);
         mdl_cmp(1, ir_b, ov_b, busy_b, ridx_b, rblk_b, rkey_b, oc_b);
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic accept_a(input logic [127:0] p, input logic [127:0] k);
      ib_a = p;
      ik_a = k;
      iv_a = 1'b1;
      @(posedge clk); #1;
      iv_a = 1'b0;
   endtask

   task automatic wait_a(input string nm, input logic [127:0] expc);
      int cnt;
      cnt = 0;
      while (!ov_a && cnt < 100) begin
         @(posedge clk); #1;
         cnt++;
      end
      chk({nm, "_latency"}, 128'(cnt), 128'd10);
      chk({nm, "_cipher"}, oc_a, expc);
   endtask

   task automatic handshake_a();
      or_a = 1'b1;
      @(posedge clk); #1;
      or_a = 1'b0;
   endtask

   int           cnt, n5, nacc, nout, cyc;
   int           acc_t [2];
   logic [127:0] outq [2];
   logic [127:0] hold;
   logic         pend_acc, pend_out;

   initial begin
      rst = 1'b0;
      iv_a = 1'b0; or_a = 1'b0; ib_a = '0; ik_a = '0;
      iv_b = 1'b0; or_b = 1'b0; ib_b = '0; ik_b = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_in_ready", 128'(ir_a), 128'd1);
      chk("reset_out_valid", 128'(ov_a), 128'd0);
      chk("reset_rnd_block", rblk_a, 128'd0);
      rst = 1'b1;
      @(posedge clk); #1;

      // FIPS-197 Appendix B on the real round
      accept_a(FIPS_P, FIPS_K);
      chk("fips_r0_idx", 128'(ridx_a), 128'd0);
      chk("fips_r0_block", rblk_a, 128'h193de3bea0f4e22b9ac68d2ae9f84808);
      wait_a("fips", FIPS_C);
      handshake_a();

      // stub round, latency 3
      ib_b = 128'h0123456789abcdef_fedcba98765432f0;
      ik_b = 128'h0000000000000000_000000000000000f;
      iv_b = 1'b1;
      @(posedge clk); #1;
      iv_b = 1'b0;
      cnt = 0;
      n5 = 0;
      while (!ov_b && cnt < 200) begin
         if (ridx_b == 4'd5) n5++;
         @(posedge clk); #1;
         cnt++;
      end
      chk("stub_latency", 128'(cnt), 128'd30);
      chk("stub_idx5_cycles", 128'(n5), 128'd3);
      chk("stub_cipher", oc_b, 128'h0123456789abcdef_fedcba9876543309);
      or_b = 1'b1;
      @(posedge clk); #1;
      or_b = 1'b0;

      // output backpressure with a competing block on offer
      accept_a(FIPS_P, FIPS_K);
      wait_a("bp_first", FIPS_C);
      ib_a = APPC_P;
      ik_a = APPC_K;
      iv_a = 1'b1;
      hold = oc_a;
      repeat (5) begin
         @(posedge clk); #1;
         chk("bp_cipher_stable", oc_a, hold);
         chk("bp_in_ready", 128'(ir_a), 128'd0);
         chk("bp_out_valid", 128'(ov_a), 128'd1);
      end
      or_a = 1'b1;
      @(posedge clk); #1;
      or_a = 1'b0;
      chk("bp_release_in_ready", 128'(ir_a), 128'd1);
      chk("bp_release_out_valid", 128'(ov_a), 128'd0);
      @(posedge clk); #1;
      iv_a = 1'b0;
      chk("bp_new_accept_busy", 128'(busy_a), 128'd1);
      wait_a("bp_second", APPC_C);
      handshake_a();

      // reset in the middle of round 4
      accept_a(APPC_P, APPC_K);
      cnt = 0;
      while (ridx_a != 4'd4 && cnt < 50) begin
         @(posedge clk); #1;
         cnt++;
      end
      chk("midrst_reached_round4", 128'(ridx_a), 128'd4);
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      chk("midrst_in_ready", 128'(ir_a), 128'd1);
      chk("midrst_out_valid", 128'(ov_a), 128'd0);
      chk("midrst_rnd_idx", 128'(ridx_a), 128'd0);
      chk("midrst_rnd_block", rblk_a, 128'd0);
      accept_a(FIPS_P, FIPS_K);
      wait_a("midrst_after", FIPS_C);
      handshake_a();

      // back-to-back blocks, in_valid and out_ready held high
      ib_a = FIPS_P;
      ik_a = FIPS_K;
      iv_a = 1'b1;
      or_a = 1'b1;
      nacc = 0;
      nout = 0;
      cyc = 0;
      acc_t[0] = 0; acc_t[1] = 0;
      outq[0] = '0; outq[1] = '0;
      while (nout < 2 && cyc < 100) begin
         pend_acc = iv_a && ir_a;
         pend_out = ov_a && or_a;
         if (pend_out) outq[nout] = oc_a;
         @(posedge clk); #1;
         cyc++;
         if (pend_acc) begin
            acc_t[nacc] = cyc;
            nacc++;
            if (nacc == 1) begin
               ib_a = APPC_P;
               ik_a = APPC_K;
            end else begin
               iv_a = 1'b0;
            end
         end
         if (pend_out) nout++;
      end
      or_a = 1'b0;
      chk("b2b_accept_spacing", 128'(acc_t[1] - acc_t[0]), 128'd12);
      chk("b2b_cipher0", outq[0], FIPS_C);
      chk("b2b_cipher1", outq[1], APPC_C);
      repeat (2) @(posedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached before the summary");
      $fatal(1);
   end

endmodule
